// File: rtl/plru_pkg.sv
// Shared types and constants for the tree pseudo-LRU tracker.
//  - plru_state_e : sweep/run controller states
//  - MAX_WAYS     : largest associativity the tracker is built for
//  - is_pow2      : helper for elaboration-time parameter checks
package plru_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } plru_state_e;

    localparam int MAX_WAYS = 16;

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/plru_tree_logic.sv
// Purely combinational tree pseudo-LRU logic for one set.
// Tree node i has children 2i+1 (left, lower ways) and 2i+2 (right).
// A node bit of 0 means the victim lies in the left subtree, 1 the right.
// Ports:
//  tree       in   WAYS-1   current tree bits of the set
//  way        in   WAY_W    accessed way (drives next_tree)
//  lock_mask  in   WAYS     ways excluded from victim selection
//  next_tree  out  WAYS-1   tree after an access to 'way'
//  victim     out  WAY_W    victim way chosen from 'tree'
//  all_locked out  1        every way is set in lock_mask
module plru_tree_logic #(
    parameter  int WAYS  = 4,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  tree,
    input  logic [WAY_W-1:0] way,
    input  logic [WAYS-1:0]  lock_mask,
    output logic [WAYS-2:0]  next_tree,
    output logic [WAY_W-1:0] victim,
    output logic             all_locked
);

    // Walk the root-to-leaf path of 'way' and point every node away from it.
    always_comb begin
        int node;
        next_tree = tree;
        node      = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            next_tree[node] = ~way[WAY_W-1-lvl];
            node            = 2 * node + 1 + int'(way[WAY_W-1-lvl]);
        end
    end

    // Follow the tree bits to a leaf, steering around fully locked subtrees.
    always_comb begin
        logic [2*WAYS-1:0] lk;
        int                node;
        logic              take;
        logic              use_mask;
        // lk is a heap of "everything below this node is locked" flags; leaves
        // sit at WAYS-1.., internal nodes are folded bottom-up.
        lk = {(2*WAYS){1'b0}};
        for (int w = 0; w < WAYS; w++) begin
            lk[WAYS-1+w] = lock_mask[w];
        end
        for (int n = WAYS - 2; n >= 0; n--) begin
            lk[n] = lk[2*n+1] & lk[2*n+2];
        end
        all_locked = lk[0];
        // With every way locked the plain tree choice is returned.
        use_mask   = ~lk[0];
        victim     = {WAY_W{1'b0}};
        node       = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            if (tree[node]) begin
                take = (use_mask && lk[2*node+2]) ? 1'b0 : 1'b1;
            end else begin
                take = (use_mask && lk[2*node+1]) ? 1'b1 : 1'b0;
            end
            victim[WAY_W-1-lvl] = take;
            node                = 2 * node + 1 + int'(take);
        end
    end

endmodule

// File: rtl/plru_tracker.sv
// Per-set tree pseudo-LRU state store with registered victim lookup and
// read-modify-write update, for any power-of-2 associativity.
// The state array has no reset: after rst0 a sweep clears one set per cycle,
// and init_done rises once every set has been cleared.
// Optional build macro: PLRU_WAYLOCK_EN enables lock-mask steering of the
// victim and the rd_all_locked flag; without it rd_lock_mask is ignored and
// rd_all_locked is tied 0.
// Ports:
//  clk0          in   1        clock
//  rst0          in   1        asynchronous active-high reset
//  init_done     out  1        sweep complete, ports accepted
//  rd_en         in   1        lookup request
//  rd_addr       in   S_INDEX  lookup set
//  rd_lock_mask  in   WAYS     ways excluded from victim
//  rd_valid      out  1        rd_victim valid this cycle
//  rd_victim     out  WAY_W    victim way
//  rd_all_locked out  1        every way masked
//  upd_en        in   1        hit/fill notification
//  upd_addr      in   S_INDEX  accessed set
//  upd_way       in   WAY_W    accessed way
module plru_tracker
    import plru_pkg::*;
#(
    parameter  int S_INDEX = 4,
    parameter  int WAYS    = 4,
    localparam int WAY_W   = $clog2(WAYS)
) (
    input  logic               clk0,
    input  logic               rst0,
    output logic               init_done,
    input  logic               rd_en,
    input  logic [S_INDEX-1:0] rd_addr,
    input  logic [WAYS-1:0]    rd_lock_mask,
    output logic               rd_valid,
    output logic [WAY_W-1:0]   rd_victim,
    output logic               rd_all_locked,
    input  logic               upd_en,
    input  logic [S_INDEX-1:0] upd_addr,
    input  logic [WAY_W-1:0]   upd_way
);

    localparam int                 NUM_SETS = 2 ** S_INDEX;
    localparam int                 TREE_W   = WAYS - 1;
    localparam logic [S_INDEX-1:0] LAST_SET = {S_INDEX{1'b1}};
    localparam logic [S_INDEX-1:0] ONE_SET  = S_INDEX'(1'b1);

    if (!is_pow2(WAYS) || (WAYS > MAX_WAYS)) begin : g_bad_ways
        $error("plru_tracker: WAYS must be a power of 2 between 2 and MAX_WAYS");
    end

    plru_state_e        state_r;
    plru_state_e        state_s;
    logic [S_INDEX-1:0] sweep_cnt_r;
    logic [S_INDEX-1:0] sweep_cnt_s;
    logic [TREE_W-1:0]  mem_r [NUM_SETS];

    logic               mem_we_s;
    logic [S_INDEX-1:0] mem_waddr_s;
    logic [TREE_W-1:0]  mem_wdata_s;
    logic               upd_go_s;
    logic               rd_go_s;

    logic [TREE_W-1:0]  upd_cur_s;
    logic [TREE_W-1:0]  upd_next_s;
    logic [TREE_W-1:0]  rd_cur_s;
    logic [WAY_W-1:0]   rd_victim_s;
    logic               rd_all_locked_s;
    logic [WAYS-1:0]    lock_s;

    logic               init_done_r;
    logic               rd_valid_r;
    logic [WAY_W-1:0]   rd_victim_r;
    logic               rd_all_locked_r;

    logic [WAY_W-1:0]   unused_upd_victim_s;
    logic               unused_upd_all_locked_s;
    logic [TREE_W-1:0]  unused_rd_next_s;

`ifdef PLRU_WAYLOCK_EN
    assign lock_s        = rd_lock_mask;
    assign rd_all_locked = rd_all_locked_r;
`else
    logic unused_lock_s;
    assign lock_s        = {WAYS{1'b0}};
    assign rd_all_locked = 1'b0;
    assign unused_lock_s = ^{rd_lock_mask, rd_all_locked_r};
`endif

    // Sweep/run controller: chooses the array write and gates the request ports.
    always_comb begin
        state_s     = state_r;
        sweep_cnt_s = sweep_cnt_r;
        mem_we_s    = 1'b0;
        mem_waddr_s = upd_addr;
        mem_wdata_s = upd_next_s;
        upd_go_s    = 1'b0;
        rd_go_s     = 1'b0;
        case (state_r)
            INIT: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = sweep_cnt_r;
                mem_wdata_s = {TREE_W{1'b0}};
                if (sweep_cnt_r == LAST_SET) begin
                    state_s     = RUN;
                    sweep_cnt_s = {S_INDEX{1'b0}};
                end else begin
                    sweep_cnt_s = sweep_cnt_r + ONE_SET;
                end
            end
            RUN: begin
                upd_go_s = upd_en;
                rd_go_s  = rd_en;
                mem_we_s = upd_en;
            end
            default: begin
                state_s     = INIT;
                sweep_cnt_s = {S_INDEX{1'b0}};
            end
        endcase
    end

    // Read the current trees; a same-cycle update to the lookup set is forwarded.
    always_comb begin
        upd_cur_s = mem_r[upd_addr];
        if (upd_go_s && (upd_addr == rd_addr)) begin
            rd_cur_s = upd_next_s;
        end else begin
            rd_cur_s = mem_r[rd_addr];
        end
    end

    plru_tree_logic #(.WAYS(WAYS)) u_upd_tree (
        .tree       (upd_cur_s),
        .way        (upd_way),
        .lock_mask  ({WAYS{1'b0}}),
        .next_tree  (upd_next_s),
        .victim     (unused_upd_victim_s),
        .all_locked (unused_upd_all_locked_s)
    );

    plru_tree_logic #(.WAYS(WAYS)) u_rd_tree (
        .tree       (rd_cur_s),
        .way        (upd_way),
        .lock_mask  (lock_s),
        .next_tree  (unused_rd_next_s),
        .victim     (rd_victim_s),
        .all_locked (rd_all_locked_s)
    );

    // Tree state array; cleared by the sweep rather than by reset.
    always_ff @(posedge clk0) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Controller state and registered lookup outputs.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state_r         <= INIT;
            sweep_cnt_r     <= {S_INDEX{1'b0}};
            init_done_r     <= 1'b0;
            rd_valid_r      <= 1'b0;
            rd_victim_r     <= {WAY_W{1'b0}};
            rd_all_locked_r <= 1'b0;
        end else begin
            state_r         <= state_s;
            sweep_cnt_r     <= sweep_cnt_s;
            init_done_r     <= (state_s == RUN);
            rd_valid_r      <= rd_go_s;
            rd_all_locked_r <= rd_go_s & rd_all_locked_s;
            if (rd_go_s) begin
                rd_victim_r <= rd_victim_s;
            end
        end
    end

    assign init_done = init_done_r;
    assign rd_valid  = rd_valid_r;
    assign rd_victim = rd_victim_r;

endmodule

// File: tb/tb_plru_tracker.sv
// Directed bench for plru_tracker (WAYS=4, S_INDEX=4). Expected lookup
// results are queued when a request is driven and compared when rd_valid
// is due one cycle later.
module tb_plru_tracker;

    localparam int S_INDEX = 4;
    localparam int WAYS    = 4;
    localparam int WAY_W   = 2;

    logic               clk0 = 1'b0;
    logic               rst0;
    logic               init_done;
    logic               rd_en;
    logic [S_INDEX-1:0] rd_addr;
    logic [WAYS-1:0]    rd_lock_mask;
    logic               rd_valid;
    logic [WAY_W-1:0]   rd_victim;
    logic               rd_all_locked;
    logic               upd_en;
    logic [S_INDEX-1:0] upd_addr;
    logic [WAY_W-1:0]   upd_way;

    int               checks = 0;
    int               errors = 0;
    logic [WAY_W:0]   exp_q[$];
    bit               pend_valid = 1'b0;

    plru_tracker #(.S_INDEX(S_INDEX), .WAYS(WAYS)) dut (
        .clk0          (clk0),
        .rst0          (rst0),
        .init_done     (init_done),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_lock_mask  (rd_lock_mask),
        .rd_valid      (rd_valid),
        .rd_victim     (rd_victim),
        .rd_all_locked (rd_all_locked),
        .upd_en        (upd_en),
        .upd_addr      (upd_addr),
        .upd_way       (upd_way)
    );

    always #5 clk0 = ~clk0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        rd_en        = 1'b0;
        rd_lock_mask = {WAYS{1'b0}};
        upd_en       = 1'b0;
    endtask

    // One clock: sample #1 after the edge, score any due lookup, idle inputs.
    task automatic tick();
        bit             exp_v;
        logic [WAY_W:0] e;
        exp_v      = pend_valid;
        pend_valid = 1'b0;
        @(posedge clk0);
        #1;
        check("rd_valid", rd_valid, exp_v);
        if (exp_v) begin
            e = exp_q.pop_front();
            check("rd_victim", rd_victim, e[WAY_W-1:0]);
            check("rd_all_locked", rd_all_locked, e[WAY_W]);
        end
        clear_inputs();
    endtask

    task automatic lookup(input logic [S_INDEX-1:0] a, input logic [WAYS-1:0] m,
                          input logic [WAY_W-1:0] v, input logic al);
        rd_en        = 1'b1;
        rd_addr      = a;
        rd_lock_mask = m;
        exp_q.push_back({al, v});
        pend_valid = 1'b1;
    endtask

    task automatic update(input logic [S_INDEX-1:0] a, input logic [WAY_W-1:0] w);
        upd_en   = 1'b1;
        upd_addr = a;
        upd_way  = w;
    endtask

    // Sweep with ignored traffic on both ports; init_done must rise on edge 16.
    task automatic sweep();
        for (int i = 0; i < 16; i++) begin
            rd_en    = 1'b1;
            rd_addr  = 4'd0;
            upd_en   = 1'b1;
            upd_addr = 4'd0;
            upd_way  = 2'd0;
            tick();
            check("init_done_sweep", init_done, (i == 15));
        end
    endtask

    initial begin
        rst0     = 1'b1;
        rd_addr  = 4'd0;
        upd_addr = 4'd0;
        upd_way  = 2'd0;
        clear_inputs();

        // Reset values
        tick();
        tick();
        check("rst_init_done", init_done, 1'b0);
        check("rst_rd_victim", rd_victim, 2'd0);
        check("rst_rd_all_locked", rd_all_locked, 1'b0);

        // 1. Sweep then first lookup
        rst0 = 1'b0;
        sweep();
        lookup(4'd3, 4'b0000, 2'd0, 1'b0);
        tick();
        lookup(4'd0, 4'b0000, 2'd0, 1'b0);
        tick();

        // 2. Sequential updates on set 5
        update(4'd5, 2'd0);
        tick();
        lookup(4'd5, 4'b0000, 2'd2, 1'b0);
        tick();
        update(4'd5, 2'd2);
        tick();
        lookup(4'd5, 4'b0000, 2'd1, 1'b0);
        tick();
        update(4'd5, 2'd1);
        tick();
        lookup(4'd5, 4'b0000, 2'd3, 1'b0);
        tick();

        // Back-to-back updates to set 10 accumulate
        update(4'd10, 2'd0);
        tick();
        update(4'd10, 2'd3);
        tick();
        lookup(4'd10, 4'b0000, 2'd1, 1'b0);
        tick();

        // 3. Same-set update and lookup: forwarded
        update(4'd9, 2'd0);
        lookup(4'd9, 4'b0000, 2'd2, 1'b0);
        tick();

        // 4. Different sets in the same cycle, then back-to-back lookups
        update(4'd7, 2'd0);
        lookup(4'd6, 4'b0000, 2'd0, 1'b0);
        tick();
        lookup(4'd7, 4'b0000, 2'd2, 1'b0);
        tick();
        lookup(4'd5, 4'b0000, 2'd3, 1'b0);
        tick();

        // 6. Lock masks on set 9 (tree after way0 access)
`ifdef PLRU_WAYLOCK_EN
        lookup(4'd9, 4'b0100, 2'd3, 1'b0);
        tick();
        lookup(4'd9, 4'b1111, 2'd2, 1'b1);
        tick();
        lookup(4'd9, 4'b1100, 2'd1, 1'b0);
        tick();
`else
        lookup(4'd9, 4'b0100, 2'd2, 1'b0);
        tick();
        lookup(4'd9, 4'b1111, 2'd2, 1'b0);
        tick();
        lookup(4'd9, 4'b1100, 2'd2, 1'b0);
        tick();
`endif

        // 5. Reset mid-traffic with a lookup in flight
        lookup(4'd5, 4'b0000, 2'd3, 1'b0);
        tick();
        rd_en    = 1'b1;
        rd_addr  = 4'd7;
        upd_en   = 1'b1;
        upd_addr = 4'd5;
        upd_way  = 2'd0;
        #2;
        rst0 = 1'b1;
        #1;
        check("midrst_rd_valid", rd_valid, 1'b0);
        check("midrst_init_done", init_done, 1'b0);
        check("midrst_rd_victim", rd_victim, 2'd0);
        clear_inputs();
        tick();
        rst0 = 1'b0;
        sweep();
        lookup(4'd5, 4'b0000, 2'd0, 1'b0);
        tick();
        lookup(4'd7, 4'b0000, 2'd0, 1'b0);
        tick();
        lookup(4'd10, 4'b0000, 2'd0, 1'b0);
        tick();
        tick();

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
